// File: rtl/ooo_decode_queue.sv
// Decode queue: decodes LEGv8-style instructions into control bundles and buffers them
// in a DEPTH-entry FIFO with branch-in-flight throttling. Define DECODE_MULDIV_EN to decode MUL/DIV.
module ooo_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int MAX_BR = 2,
  parameter int REG_W  = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [17:0]                 instr_i,
  input  logic                        instr_valid_i,
  output logic                        instr_ready_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [3:0]                  cmd_type_o,
  output logic [REG_W-1:0]            reg_rd_o,
  output logic [2:0]                  alu_op_o,
  output logic [1:0]                  which_math_o,
  output logic                        reg_write_o,
  output logic                        mem_write_o,
  output logic                        mem_to_reg_o,
  output logic                        alu_src_o,
  output logic                        save_cond_o,
  output logic                        left_shift_o,
  output logic                        is_branch_o,
  input  logic                        flush_i,
  input  logic                        br_resolve_i,
  output logic [$clog2(MAX_BR+1)-1:0] br_inflight_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BR_W  = $clog2(MAX_BR + 1);

  localparam logic [3:0] CMD_ALU  = 4'd0;
  localparam logic [3:0] CMD_STUR = 4'd1;
  localparam logic [3:0] CMD_BCND = 4'd2;
  localparam logic [3:0] CMD_CBZ  = 4'd4;
  localparam logic [3:0] CMD_BR   = 4'd6;
  localparam logic [3:0] CMD_BL   = 4'd7;
  localparam logic [3:0] CMD_B    = 4'd8;
  localparam logic [3:0] CMD_LDUR = 4'd9;

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_ORR = 3'd5;
  localparam logic [2:0] OP_EOR = 3'd6;

  typedef struct packed {
    logic [3:0]       cmd_type;
    logic [REG_W-1:0] reg_rd;
    logic [2:0]       alu_op;
    logic [1:0]       which_math;
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             save_cond;
    logic             left_shift;
    logic             is_branch;
  } entry_t;

  entry_t            dec;
  logic              dec_ok;
  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              enq, deq, br_enq, br_ret;
  logic [10:0]       opcode;
  logic              unused_ok;

  assign opcode    = instr_i[10:0];
  assign unused_ok = ^instr_i;

  // NOTE: every field gets a default before the case, so no latch can be inferred.
  always_comb begin
    dec        = '0;
    dec_ok     = 1'b1;
    dec.reg_rd = instr_i[12 +: REG_W];
    casez (opcode)
      11'b10001011000: begin dec.alu_op = OP_ADD; dec.reg_write = 1'b1; end
      11'b10101011000: begin dec.alu_op = OP_ADD; dec.reg_write = 1'b1; dec.save_cond = 1'b1; end
      11'b1001000100?: begin dec.alu_op = OP_ADD; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      11'b11001011000: begin dec.alu_op = OP_SUB; dec.reg_write = 1'b1; end
      11'b11101011000: begin dec.alu_op = OP_SUB; dec.reg_write = 1'b1; dec.save_cond = 1'b1; end
      11'b10001010000: begin dec.alu_op = OP_AND; dec.reg_write = 1'b1; end
      11'b10101010000: begin dec.alu_op = OP_ORR; dec.reg_write = 1'b1; end
      11'b11001010000: begin dec.alu_op = OP_EOR; dec.reg_write = 1'b1; end
      11'b11010011011: begin
        dec.which_math = 2'd1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.left_shift = 1'b1;
      end
      11'b11010011010: begin dec.which_math = 2'd1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
`ifdef DECODE_MULDIV_EN
      11'b10011011000: begin dec.which_math = 2'd2; dec.reg_write = 1'b1; end
      11'b10011010110: begin dec.which_math = 2'd3; dec.reg_write = 1'b1; end
`endif
      11'b11111000010: begin
        dec.cmd_type = CMD_LDUR; dec.alu_op = OP_ADD; dec.alu_src = 1'b1;
        dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
      end
      11'b11111000000: begin
        dec.cmd_type = CMD_STUR; dec.alu_op = OP_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
      end
      11'b000101?????: begin dec.cmd_type = CMD_B; dec.is_branch = 1'b1; end
      11'b100101?????: begin
        dec.cmd_type = CMD_BL; dec.is_branch = 1'b1; dec.reg_write = 1'b1;
        dec.reg_rd = REG_W'(30);
      end
      11'b11010110000: begin dec.cmd_type = CMD_BR;   dec.is_branch = 1'b1; end
      11'b10110100???: begin dec.cmd_type = CMD_CBZ;  dec.is_branch = 1'b1; end
      11'b01010100???: begin dec.cmd_type = CMD_BCND; dec.is_branch = 1'b1; end
      default:         dec_ok = 1'b0;
    endcase
  end

  assign instr_ready_o = (count != CNT_W'(DEPTH)) && !flush_i &&
                         !(dec.is_branch && (br_inflight_o == BR_W'(MAX_BR)));
  assign out_valid_o   = (count != '0);

  // Unrecognised opcodes complete the handshake but never reach the queue.
  assign enq    = instr_valid_i && instr_ready_o && dec_ok;
  assign deq    = out_valid_o && out_ready_i;
  assign br_enq = enq && dec.is_branch;
  assign br_ret = br_resolve_i && (br_inflight_o != '0);

  // NOTE: the payload array has no reset; out_valid_o gates everything read from it.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= dec;
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      br_inflight_o <= '0;
    end else if (flush_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      br_inflight_o <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      case ({br_enq, br_ret})
        2'b10:   br_inflight_o <= br_inflight_o + BR_W'(1);
        2'b01:   br_inflight_o <= br_inflight_o - BR_W'(1);
        default: ;
      endcase
    end
  end

  assign head         = out_valid_o ? mem[rd_ptr] : '0;
  assign cmd_type_o   = head.cmd_type;
  assign reg_rd_o     = head.reg_rd;
  assign alu_op_o     = head.alu_op;
  assign which_math_o = head.which_math;
  assign reg_write_o  = head.reg_write;
  assign mem_write_o  = head.mem_write;
  assign mem_to_reg_o = head.mem_to_reg;
  assign alu_src_o    = head.alu_src;
  assign save_cond_o  = head.save_cond;
  assign left_shift_o = head.left_shift;
  assign is_branch_o  = head.is_branch;

endmodule

// File: tb/tb_ooo_decode_queue.sv
// Self-checking bench for ooo_decode_queue: directed scenarios followed by random traffic,
// checked against an instruction-kind level queue model. Honours DECODE_MULDIV_EN.
module tb_ooo_decode_queue;

  localparam int DEPTH  = 4;
  localparam int MAX_BR = 2;

  typedef enum int {
    K_ADD, K_ADDS, K_ADDI, K_SUB, K_SUBS, K_AND, K_ORR, K_EOR, K_LSL, K_LSR,
    K_MUL, K_DIV, K_LDUR, K_STUR, K_B, K_BL, K_BR, K_CBZ, K_BCOND, K_BAD
  } kind_e;

  typedef struct packed {
    logic [3:0] cmd;
    logic [4:0] rd;
    logic [2:0] alu;
    logic [1:0] wm;
    logic rw, mw, m2r, asrc, sc, ls, br;
  } ent_t;

  logic        clk, rst_n;
  logic [17:0] instr;
  logic        instr_valid, instr_ready, out_valid, out_ready;
  logic [3:0]  cmd_type;
  logic [4:0]  reg_rd;
  logic [2:0]  alu_op;
  logic [1:0]  which_math;
  logic        reg_write, mem_write, mem_to_reg, alu_src, save_cond, left_shift, is_branch;
  logic        flush, br_resolve;
  logic [1:0]  br_inflight;
  logic [20:0] head_obs;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t exp_q[$];
  int   br_cnt = 0;

  ooo_decode_queue #(.DEPTH(DEPTH), .MAX_BR(MAX_BR), .REG_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .instr_i(instr), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .cmd_type_o(cmd_type), .reg_rd_o(reg_rd), .alu_op_o(alu_op), .which_math_o(which_math),
    .reg_write_o(reg_write), .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg),
    .alu_src_o(alu_src), .save_cond_o(save_cond), .left_shift_o(left_shift),
    .is_branch_o(is_branch), .flush_i(flush), .br_resolve_i(br_resolve),
    .br_inflight_o(br_inflight)
  );

  assign head_obs = {cmd_type, reg_rd, alu_op, which_math, reg_write, mem_write,
                     mem_to_reg, alu_src, save_cond, left_shift, is_branch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_br(kind_e k);
    return k inside {K_B, K_BL, K_BR, K_CBZ, K_BCOND};
  endfunction

  function automatic logic recognised(kind_e k);
`ifdef DECODE_MULDIV_EN
    return k != K_BAD;
`else
    return !(k inside {K_BAD, K_MUL, K_DIV});
`endif
  endfunction

  function automatic logic [17:0] encode(kind_e k, int rd);
    logic [10:0] op;
    logic [5:0]  r6;
    logic        r1;
    r6 = 6'($urandom);
    r1 = 1'($urandom);
    case (k)
      K_ADD:   op = 11'h458;
      K_ADDS:  op = 11'h558;
      K_ADDI:  op = {10'b1001000100, r1};
      K_SUB:   op = 11'h658;
      K_SUBS:  op = 11'h758;
      K_AND:   op = 11'h450;
      K_ORR:   op = 11'h550;
      K_EOR:   op = 11'h650;
      K_LSL:   op = 11'h69B;
      K_LSR:   op = 11'h69A;
      K_MUL:   op = 11'h4D8;
      K_DIV:   op = 11'h4D6;
      K_LDUR:  op = 11'h7C2;
      K_STUR:  op = 11'h7C0;
      K_B:     op = {6'b000101, r6[4:0]};
      K_BL:    op = {6'b100101, r6[4:0]};
      K_BR:    op = 11'h6B0;
      K_CBZ:   op = {8'b10110100, r6[2:0]};
      K_BCOND: op = {8'b01010100, r6[2:0]};
      default: op = {5'b00000, r6};
    endcase
    return {rd[5:0], r1, op};
  endfunction

  // Control bundle each instruction kind must produce.
  function automatic ent_t exp_of(kind_e k, int rd);
    ent_t e;
    e    = '0;
    e.rd = rd[4:0];
    case (k)
      K_ADD:   begin e.alu = 3'd2; e.rw = 1'b1; end
      K_ADDS:  begin e.alu = 3'd2; e.rw = 1'b1; e.sc = 1'b1; end
      K_ADDI:  begin e.alu = 3'd2; e.rw = 1'b1; e.asrc = 1'b1; end
      K_SUB:   begin e.alu = 3'd3; e.rw = 1'b1; end
      K_SUBS:  begin e.alu = 3'd3; e.rw = 1'b1; e.sc = 1'b1; end
      K_AND:   begin e.alu = 3'd4; e.rw = 1'b1; end
      K_ORR:   begin e.alu = 3'd5; e.rw = 1'b1; end
      K_EOR:   begin e.alu = 3'd6; e.rw = 1'b1; end
      K_LSL:   begin e.wm = 2'd1; e.rw = 1'b1; e.asrc = 1'b1; e.ls = 1'b1; end
      K_LSR:   begin e.wm = 2'd1; e.rw = 1'b1; e.asrc = 1'b1; end
      K_MUL:   begin e.wm = 2'd2; e.rw = 1'b1; end
      K_DIV:   begin e.wm = 2'd3; e.rw = 1'b1; end
      K_LDUR:  begin e.cmd = 4'd9; e.alu = 3'd2; e.asrc = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; end
      K_STUR:  begin e.cmd = 4'd1; e.alu = 3'd2; e.asrc = 1'b1; e.mw = 1'b1; end
      K_B:     begin e.cmd = 4'd8; e.br = 1'b1; end
      K_BL:    begin e.cmd = 4'd7; e.br = 1'b1; e.rw = 1'b1; e.rd = 5'd30; end
      K_BR:    begin e.cmd = 4'd6; e.br = 1'b1; end
      K_CBZ:   begin e.cmd = 4'd4; e.br = 1'b1; end
      K_BCOND: begin e.cmd = 4'd2; e.br = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: drive, check against the model, clock, then advance the model.
  task automatic cycle(input logic v, input kind_e k, input int rd, input logic ordy,
                       input logic fl, input logic res);
    logic rdy;
    int   br_before;
    instr_valid = v;
    instr       = encode(k, rd);
    out_ready   = ordy;
    flush       = fl;
    br_resolve  = res;
    #2;
    rdy = (exp_q.size() < DEPTH) && !fl && !(is_br(k) && br_cnt == MAX_BR);
    check("instr_ready", 32'(instr_ready), 32'(rdy));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("head", 32'(head_obs), 32'(exp_q[0]));
    check("br_inflight", 32'(br_inflight), 32'(br_cnt));
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      br_cnt = 0;
    end else begin
      br_before = br_cnt;
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (v && rdy && recognised(k)) begin
        exp_q.push_back(exp_of(k, rd));
        if (is_br(k)) br_cnt++;
      end
      if (res && br_before > 0) br_cnt--;
    end
    instr_valid = 1'b0;
    flush       = 1'b0;
    br_resolve  = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, K_ADD, 0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; out_ready = 1'b0;
    flush = 1'b0; br_resolve = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'(head_obs), 32'd0);
    check("reset_br", 32'(br_inflight), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD rd=3 is visible at the head one cycle after acceptance.
    cycle(1'b1, K_ADD, 3, 1'b1, 1'b0, 1'b0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_cmd", 32'(cmd_type), 32'd0);
    check("add_alu_op", 32'(alu_op), 32'd2);
    check("add_rd", 32'(reg_rd), 32'd3);
    check("add_reg_write", 32'(reg_write), 32'd1);
    idle(1'b1);

    // Fill to DEPTH, observe back-pressure, one dequeue frees a slot, drain in order.
    cycle(1'b1, K_SUB, 5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_AND, 6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_LDUR, 7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_STUR, 8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_ORR, 9, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b1, K_EOR, 10, 1'b0, 1'b0, 1'b0);
    repeat (5) idle(1'b1);

    // Branch throttle at MAX_BR, released by a resolve pulse.
    cycle(1'b1, K_B, 1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_CBZ, 2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_BCOND, 3, 1'b0, 1'b0, 1'b0);
    check("br_full", 32'(br_inflight), 32'd2);
    cycle(1'b1, K_BCOND, 3, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, K_BCOND, 3, 1'b0, 1'b0, 1'b0);
    check("br_after_resolve", 32'(br_inflight), 32'd2);

    // Flush with three entries queued and a valid instruction presented.
    cycle(1'b1, K_ADD, 4, 1'b1, 1'b1, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_br", 32'(br_inflight), 32'd0);
    idle(1'b0);

    // MUL: decoded only when the mul/div unit is enabled.
    cycle(1'b1, K_MUL, 7, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_MULDIV_EN
    check("mul_which_math", 32'(which_math), 32'd2);
`else
    check("mul_dropped", 32'(out_valid), 32'd0);
`endif
    idle(1'b1);

    // Every kind at least once, then random traffic.
    for (int k = 0; k <= int'(K_BAD); k++) begin
      cycle(1'b1, kind_e'(k), int'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, kind_e'($urandom_range(0, int'(K_BAD))),
            int'($urandom_range(0, 63)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-stream with two entries queued.
    cycle(1'b1, K_ADD, 0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, K_ADD, 11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, K_B, 12, 1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_br", 32'(br_inflight), 32'd0);
    check("async_reset_outputs", 32'(head_obs), 32'd0);
    exp_q.delete();
    br_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, K_BL, 13, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ooo_decode_queue.md
OOO_DECODE_QUEUE -- requirements
Module: ooo_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_BR, default 2, meaning max unresolved branches in flight (>=1).
REQ-003 SHALL have parameter REG_W, default 5, meaning destination register index width.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port instr_i, input, 18, meaning the instruction: [17:12] rd field, [10:0] opcode field.
REQ-007 SHALL have port instr_valid_i / instr_ready_o, input/output, 1 each, meaning the upstream handshake.
REQ-008 SHALL have port out_valid_o / out_ready_i, output/input, 1 each, meaning the downstream handshake.
REQ-009 SHALL have port cmd_type_o, output, 4, meaning 0 ALU, 1 STUR, 2 B.cond, 4 CBZ, 6 BR, 7 BL, 8 B, 9 LDUR.
REQ-010 SHALL have port reg_rd_o, output, REG_W, meaning destination register (instr_i[12+REG_W-1:12]; BL forces 30).
REQ-011 SHALL have ports alu_op_o (3) and which_math_o (2), output, meaning ALU op (2 add, 3 sub, 4 and, 5 orr, 6 eor) and unit (0 ALU, 1 shift, 2 mul, 3 div).
REQ-012 SHALL have ports reg_write_o, mem_write_o, mem_to_reg_o, alu_src_o, save_cond_o, left_shift_o, is_branch_o, output, 1 each, meaning the decoded control bits.
REQ-013 SHALL have port flush_i, input, 1, meaning squash all queued entries.
REQ-014 SHALL have port br_resolve_i, input, 1, meaning one in-flight branch retired.
REQ-015 SHALL have port br_inflight_o, output, $clog2(MAX_BR+1), meaning the unresolved-branch count.

Function
REQ-016 SHALL decode ADDI, ADD(S), SUB(S), AND, ORR, EOR, LSL, LSR, MUL, DIV, LDUR, STUR, B, BL, BR, CBZ, B.cond with the team ISA encoding table and control values unchanged from the single-cycle decoder.
REQ-017 SHALL accept an instruction when instr_valid_i && instr_ready_o; decoded fields are registered, so an entry accepted in cycle N is first visible at the queue head in cycle N+1.
REQ-018 SHALL consume unrecognised opcodes (handshake completes) without enqueuing an entry.
REQ-019 SHALL present the head entry fields whenever out_valid_o=1; fields are don't-care when out_valid_o=0; out_valid_o = (count != 0).
REQ-020 SHALL hold the head entry stable while out_valid_o && !out_ready_i.
REQ-021 SHALL drive instr_ready_o=0 when count==DEPTH, when flush_i=1, or when the instruction decodes as a branch (is_branch) and br_inflight_o==MAX_BR.
REQ-022 SHALL allow enqueue and dequeue in the same cycle; count is then unchanged; pointers wrap modulo DEPTH.
REQ-023 SHALL increment br_inflight_o when a branch is enqueued and decrement it on br_resolve_i; both together leave it unchanged; br_resolve_i at 0 is ignored.
REQ-024 SHALL, on flush_i, empty the queue and clear br_inflight_o next cycle, ignoring same-cycle enqueue, dequeue and br_resolve_i.

Reset
REQ-025 SHALL, while rst_n_i=0, asynchronously clear pointers, count and br_inflight_o, giving out_valid_o=0 and all decoded outputs 0.
REQ-026 SHALL discard any in-progress handshake on reset; instr_ready_o=1 in the first cycle after release.

Configuration
REQ-027 SHALL honour macro DECODE_MULDIV_EN: defined -> MUL/DIV decode per REQ-011 (which_math_o 2/3); undefined -> MUL/DIV treated as unrecognised per REQ-018, and which_math_o never exceeds 1.

Verification
REQ-028 SHALL cover: ADD rd=3 with out_ready_i=1 -> cycle N+1 out_valid_o=1, cmd_type_o=0, alu_op_o=2, reg_rd_o=3, reg_write_o=1.
REQ-029 SHALL cover: 4 writes with out_ready_i=0 at DEPTH=4 -> instr_ready_o=0; one dequeue -> instr_ready_o=1 next cycle; FIFO order preserved.
REQ-030 SHALL cover: MAX_BR=2, enqueue B, CBZ, then present B.cond -> instr_ready_o=0, br_inflight_o=2; pulse br_resolve_i -> accepted, br_inflight_o stays 2.
REQ-031 SHALL cover: 3 entries queued plus flush_i with a valid instruction -> next cycle out_valid_o=0, br_inflight_o=0, instruction not enqueued.
REQ-032 SHALL cover: MUL presented -> with DECODE_MULDIV_EN which_math_o=2; without, consumed with out_valid_o staying 0.
REQ-033 SHALL cover: rst_n_i low mid-stream with 2 entries queued -> immediately out_valid_o=0, br_inflight_o=0.
